// File: rtl/spi_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_arb_pkg                                                  |
// | Description : Shared types and constants for the SPI flash pin arbiter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic       PIN_IDLE_CSN = 1'b1;
    localparam logic       PIN_IDLE_SCK = 1'b0;
    localparam logic [3:0] PIN_IDLE_DQ  = 4'h0;
    localparam logic [3:0] PIN_IDLE_OE  = 4'h0;

    localparam logic OWNER_0 = 1'b0;
    localparam logic OWNER_1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spi_arb_pin_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_arb_pin_reg                                              |
// | Description : Registered 2:1 flash pin mux with idle force; resets idle.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_arb_pin_reg
    import spi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sel,
    input  logic       i_force_idle,
    input  logic       i_csn0,
    input  logic       i_sck0,
    input  logic [3:0] i_dq0,
    input  logic [3:0] i_oe0,
    input  logic       i_csn1,
    input  logic       i_sck1,
    input  logic [3:0] i_dq1,
    input  logic [3:0] i_oe1,
    output logic       o_csn,
    output logic       o_sck,
    output logic [3:0] o_dq,
    output logic [3:0] o_oe
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_csn <= PIN_IDLE_CSN;
            o_sck <= PIN_IDLE_SCK;
            o_dq  <= PIN_IDLE_DQ;
            o_oe  <= PIN_IDLE_OE;
        end else if (i_force_idle) begin
            o_csn <= PIN_IDLE_CSN;
            o_sck <= PIN_IDLE_SCK;
            o_dq  <= PIN_IDLE_DQ;
            o_oe  <= PIN_IDLE_OE;
        end else if (i_sel) begin
            o_csn <= i_csn1;
            o_sck <= i_sck1;
            o_dq  <= i_dq1;
            o_oe  <= i_oe1;
        end else begin
            o_csn <= i_csn0;
            o_sck <= i_sck0;
            o_dq  <= i_dq0;
            o_oe  <= i_oe0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_flash_arbiter                                            |
// | Description : Two-requester transaction-level arbiter for one SPI/QSPI     |
// |               flash pin set, with a forced chip-select gap on handover.    |
// |               Optional hold-time limit: define SPI_ARB_TIMEOUT_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    output logic       gnt0,
    input  logic       csn0,
    input  logic       sck0,
    input  logic [3:0] dq0_o,
    input  logic [3:0] dq0_oe,
    output logic [3:0] dq0_i,
    input  logic       req1,
    output logic       gnt1,
    input  logic       csn1,
    input  logic       sck1,
    input  logic [3:0] dq1_o,
    input  logic [3:0] dq1_oe,
    output logic [3:0] dq1_i,
    input  logic [3:0] flash_dq_i,
    output logic       flash_csn,
    output logic       flash_sck,
    output logic [3:0] flash_dq_o,
    output logic [3:0] flash_dq_oe,
    output logic       owner,
    output logic       busy,
    output logic       abort_err,
    output logic       timeout_err
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("spi_flash_arbiter: GAP_CYCLES or TIMEOUT_CYCLES out of range");
    end

    localparam logic [7:0] c_gap_load = 8'(GAP_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic [7:0] r_gcnt;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_owner;
    logic       r_busy;
    logic       r_abort;
    logic       w_elig0;
    logic       w_elig1;
    logic       w_to0;
    logic       w_to1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] c_to_limit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tcnt;
    logic        r_block0;
    logic        r_block1;
    logic        r_tout;

    // A revoked requester stays ineligible until it lets go of req once.
    assign w_elig0     = req0 & ~r_block0;
    assign w_elig1     = req1 & ~r_block1;
    assign w_to0       = (r_state == ST_OWN0) & req0 & req1 & (r_tcnt == c_to_limit);
    assign w_to1       = (r_state == ST_OWN1) & req1 & req0 & (r_tcnt == c_to_limit);
    assign timeout_err = r_tout;
`else
    assign w_elig0     = req0;
    assign w_elig1     = req1;
    assign w_to0       = 1'b0;
    assign w_to1       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_elig0 && w_elig1) begin
                    w_next = (r_last == OWNER_1) ? ST_OWN0 : ST_OWN1;
                end else if (w_elig0) begin
                    w_next = ST_OWN0;
                end else if (w_elig1) begin
                    w_next = ST_OWN1;
                end
            end
            ST_OWN0: if (!req0 || w_to0) w_next = ST_GAP;
            ST_OWN1: if (!req1 || w_to1) w_next = ST_GAP;
            ST_GAP:  if (r_gcnt == 8'd0) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_last   <= OWNER_1;
            r_gcnt   <= 8'd0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_owner  <= OWNER_0;
            r_busy   <= 1'b0;
            r_abort  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_tcnt   <= 16'd0;
            r_block0 <= 1'b0;
            r_block1 <= 1'b0;
            r_tout   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_gnt0  <= (w_next == ST_OWN0);
            r_gnt1  <= (w_next == ST_OWN1);
            r_busy  <= (w_next != ST_IDLE);
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_OWN0) r_owner <= OWNER_0;
                    if (w_next == ST_OWN1) r_owner <= OWNER_1;
                end
                ST_OWN0: begin
                    if (w_next == ST_GAP) begin
                        r_last  <= OWNER_0;
                        r_gcnt  <= c_gap_load;
                        r_abort <= ~req0 & ~csn0;
                    end
                end
                ST_OWN1: begin
                    if (w_next == ST_GAP) begin
                        r_last  <= OWNER_1;
                        r_gcnt  <= c_gap_load;
                        r_abort <= ~req1 & ~csn1;
                    end
                end
                default: begin
                    if (r_gcnt != 8'd0) r_gcnt <= r_gcnt - 8'd1;
                end
            endcase
`ifdef SPI_ARB_TIMEOUT_EN
            r_tout <= w_to0 | w_to1;
            if ((w_next == r_state) &&
                (((r_state == ST_OWN0) && req1) || ((r_state == ST_OWN1) && req0))) begin
                r_tcnt <= r_tcnt + 16'd1;
            end else begin
                r_tcnt <= 16'd0;
            end
            if (w_to0)      r_block0 <= 1'b1;
            else if (!req0) r_block0 <= 1'b0;
            if (w_to1)      r_block1 <= 1'b1;
            else if (!req1) r_block1 <= 1'b0;
`endif
        end
    end

    // Pins follow the state being entered so they change on the same edge as the grant.
    spi_arb_pin_reg u_pin_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sel        (w_next == ST_OWN1),
        .i_force_idle ((w_next != ST_OWN0) && (w_next != ST_OWN1)),
        .i_csn0       (csn0),
        .i_sck0       (sck0),
        .i_dq0        (dq0_o),
        .i_oe0        (dq0_oe),
        .i_csn1       (csn1),
        .i_sck1       (sck1),
        .i_dq1        (dq1_o),
        .i_oe1        (dq1_oe),
        .o_csn        (flash_csn),
        .o_sck        (flash_sck),
        .o_dq         (flash_dq_o),
        .o_oe         (flash_dq_oe)
    );

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign abort_err = r_abort;
    assign dq0_i     = flash_dq_i;
    assign dq1_i     = flash_dq_i;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_flash_arbiter                                         |
// | Description : Table-driven scoreboard bench for spi_flash_arbiter.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_flash_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, csn0, sck0, csn1, sck1;
    logic [3:0] dq0_o, dq0_oe, dq1_o, dq1_oe, flash_dq_i;
    logic       gnt0, gnt1, flash_csn, flash_sck, owner, busy, abort_err, timeout_err;
    logic [3:0] flash_dq_o, flash_dq_oe, dq0_i, dq1_i;

    always #5 clk = ~clk;

    spi_flash_arbiter #(
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .gnt0        (gnt0),
        .csn0        (csn0),
        .sck0        (sck0),
        .dq0_o       (dq0_o),
        .dq0_oe      (dq0_oe),
        .dq0_i       (dq0_i),
        .req1        (req1),
        .gnt1        (gnt1),
        .csn1        (csn1),
        .sck1        (sck1),
        .dq1_o       (dq1_o),
        .dq1_oe      (dq1_oe),
        .dq1_i       (dq1_i),
        .flash_dq_i  (flash_dq_i),
        .flash_csn   (flash_csn),
        .flash_sck   (flash_sck),
        .flash_dq_o  (flash_dq_o),
        .flash_dq_oe (flash_dq_oe),
        .owner       (owner),
        .busy        (busy),
        .abort_err   (abort_err),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic        r0;
        logic        r1;
        logic [9:0]  p0;
        logic [9:0]  p1;
        logic [15:0] e;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] sb[$];
    vec_t        vt[30];

    // Requester pin bundle {csn, sck, dq, oe}.
    function automatic logic [9:0] pv(logic c, logic s, logic [3:0] d, logic [3:0] o);
        return {c, s, d, o};
    endfunction

    // Expected outputs {gnt0, gnt1, pins, busy, owner, abort_err, timeout_err}.
    function automatic logic [15:0] ex(logic [1:0] g, logic [9:0] p, logic b, logic o, logic a, logic t);
        return {g, p, b, o, a, t};
    endfunction

    function automatic vec_t mkv(logic r0, logic r1, logic [9:0] p0, logic [9:0] p1, logic [15:0] e);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.p0 = p0; v.p1 = p1; v.e = e;
        return v;
    endfunction

    task automatic drive(input logic r0, input logic r1, input logic [9:0] p0, input logic [9:0] p1);
        req0 = r0;
        req1 = r1;
        {csn0, sck0, dq0_o, dq0_oe} = p0;
        {csn1, sck1, dq1_o, dq1_oe} = p1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name);
        logic [15:0] act;
        logic [15:0] exp;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            exp = sb.pop_front();
            act = {gnt0, gnt1, flash_csn, flash_sck, flash_dq_o, flash_dq_oe,
                   busy, owner, abort_err, timeout_err};
            if (act === exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bcast(input logic [3:0] v);
        n_total++;
        if (dq0_i === v && dq1_i === v) n_pass++;
        else $display("FAIL dq_bcast: got %h/%h expected %h", dq0_i, dq1_i, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [9:0] pi;
        logic [9:0] ps;
        pi = pv(1'b1, 1'b0, 4'h0, 4'h0);
        ps = pv(1'b0, 1'b1, 4'h5, 4'hF);

        vt[0]  = mkv(1, 1, pi,                   ps,                   ex(2'b10, pi, 1, 0, 0, 0));
        vt[1]  = mkv(1, 1, pv(0, 0, 4'h3, 4'h1), pv(0, 1, 4'hC, 4'hF), ex(2'b10, pv(0, 0, 4'h3, 4'h1), 1, 0, 0, 0));
        vt[2]  = mkv(1, 1, pv(0, 1, 4'h6, 4'h3), pv(0, 0, 4'hC, 4'hF), ex(2'b10, pv(0, 1, 4'h6, 4'h3), 1, 0, 0, 0));
        vt[3]  = mkv(1, 1, pi,                   pv(0, 1, 4'h5, 4'h5), ex(2'b10, pi, 1, 0, 0, 0));
        vt[4]  = mkv(0, 1, pi,                   pv(0, 1, 4'h5, 4'h5), ex(2'b00, pi, 1, 0, 0, 0));
        vt[5]  = mkv(0, 1, pv(0, 1, 4'hF, 4'hF), pv(0, 1, 4'h5, 4'h5), ex(2'b00, pi, 1, 0, 0, 0));
        vt[6]  = mkv(0, 1, pv(0, 1, 4'hF, 4'hF), pv(0, 1, 4'h5, 4'h5), ex(2'b00, pi, 1, 0, 0, 0));
        vt[7]  = mkv(0, 1, pv(0, 1, 4'hF, 4'hF), pv(0, 1, 4'h5, 4'h5), ex(2'b00, pi, 1, 0, 0, 0));
        vt[8]  = mkv(0, 1, pv(0, 1, 4'hF, 4'hF), pv(0, 1, 4'h5, 4'h5), ex(2'b00, pi, 0, 0, 0, 0));
        vt[9]  = mkv(0, 1, pv(0, 1, 4'h5, 4'hF), pv(0, 0, 4'hA, 4'hF), ex(2'b01, pv(0, 0, 4'hA, 4'hF), 1, 1, 0, 0));
        vt[10] = mkv(1, 1, pv(0, 0, 4'h3, 4'hC), pv(0, 1, 4'hA, 4'hF), ex(2'b01, pv(0, 1, 4'hA, 4'hF), 1, 1, 0, 0));
        vt[11] = mkv(1, 1, pv(0, 1, 4'hF, 4'h0), pv(0, 0, 4'h5, 4'h0), ex(2'b01, pv(0, 0, 4'h5, 4'h0), 1, 1, 0, 0));
        vt[12] = mkv(1, 0, pv(0, 1, 4'hF, 4'hF), pv(0, 1, 4'h5, 4'h0), ex(2'b00, pi, 1, 1, 1, 0));
        vt[13] = mkv(1, 1, pv(0, 1, 4'hF, 4'hF), ps,                   ex(2'b00, pi, 1, 1, 0, 0));
        vt[14] = mkv(1, 1, pv(0, 1, 4'hF, 4'hF), ps,                   ex(2'b00, pi, 1, 1, 0, 0));
        vt[15] = mkv(1, 1, pv(0, 1, 4'hF, 4'hF), ps,                   ex(2'b00, pi, 1, 1, 0, 0));
        vt[16] = mkv(1, 1, pv(0, 1, 4'hF, 4'hF), ps,                   ex(2'b00, pi, 0, 1, 0, 0));
        vt[17] = mkv(1, 1, pv(1, 0, 4'h9, 4'hF), pv(0, 1, 4'h3, 4'h3), ex(2'b10, pv(1, 0, 4'h9, 4'hF), 1, 0, 0, 0));
        vt[18] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 1, 0, 0, 0));
        vt[19] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 1, 0, 0, 0));
        vt[20] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 1, 0, 0, 0));
        vt[21] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 1, 0, 0, 0));
        vt[22] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 0, 0, 0, 0));
        vt[23] = mkv(0, 1, pi,                   pv(0, 1, 4'h6, 4'h6), ex(2'b01, pv(0, 1, 4'h6, 4'h6), 1, 1, 0, 0));
        vt[24] = mkv(0, 0, pi,                   pi,                   ex(2'b00, pi, 1, 1, 0, 0));
        vt[25] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 1, 1, 0, 0));
        vt[26] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 1, 1, 0, 0));
        vt[27] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 1, 1, 0, 0));
        vt[28] = mkv(0, 1, pi,                   ps,                   ex(2'b00, pi, 0, 1, 0, 0));
        vt[29] = mkv(0, 1, pi,                   pv(0, 1, 4'hF, 4'hF), ex(2'b01, pv(0, 1, 4'hF, 4'hF), 1, 1, 0, 0));

        rst_n      = 1'b0;
        flash_dq_i = 4'h7;
        drive(1, 1, pi, ps);
        #12;
        sb.push_back(ex(2'b00, pi, 0, 0, 0, 0));
        check("reset_idle");
        check_bcast(4'h7);
        step();
        sb.push_back(ex(2'b00, pi, 0, 0, 0, 0));
        check("reset_held");
        rst_n      = 1'b1;
        flash_dq_i = 4'hC;
        #1;
        check_bcast(4'hC);

        for (int i = 0; i < 30; i++) begin
            drive(vt[i].r0, vt[i].r1, vt[i].p0, vt[i].p1);
            sb.push_back(vt[i].e);
            step();
            check($sformatf("vec%0d", i));
        end

        // Reset asserted while requester 1 is mid-transfer.
        drive(0, 1, pv(0, 1, 4'hA, 4'hF), pv(0, 0, 4'h3, 4'hF));
        sb.push_back(ex(2'b01, pv(0, 0, 4'h3, 4'hF), 1, 1, 0, 0));
        step();
        check("own1_shift");
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(ex(2'b00, pi, 0, 0, 0, 0));
        check("async_reset");
        step();
        sb.push_back(ex(2'b00, pi, 0, 0, 0, 0));
        check("reset_midtx_held");
        drive(0, 0, pi, pi);
        rst_n = 1'b1;
        sb.push_back(ex(2'b00, pi, 0, 0, 0, 0));
        step();
        check("post_reset_idle");

`ifdef SPI_ARB_TIMEOUT_EN
        drive(1, 1, pi, pi);
        sb.push_back(ex(2'b10, pi, 1, 0, 0, 0));
        step();
        check("to_grant0");
        for (int i = 0; i < 15; i++) begin
            sb.push_back(ex(2'b10, pi, 1, 0, 0, 0));
            step();
            check($sformatf("to_hold%0d", i));
        end
        sb.push_back(ex(2'b00, pi, 1, 0, 0, 1));
        step();
        check("to_revoke");
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex(2'b00, pi, 1, 0, 0, 0));
            step();
            check($sformatf("to_gap%0d", i));
        end
        sb.push_back(ex(2'b00, pi, 0, 0, 0, 0));
        step();
        check("to_idle");
        sb.push_back(ex(2'b01, pi, 1, 1, 0, 0));
        step();
        check("to_grant1");
        drive(1, 0, pi, pi);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(ex(2'b00, pi, 1, 1, 0, 0));
            step();
            check($sformatf("to_gap1_%0d", i));
        end
        sb.push_back(ex(2'b00, pi, 0, 1, 0, 0));
        step();
        check("to_idle1");
        sb.push_back(ex(2'b00, pi, 0, 1, 0, 0));
        step();
        check("to_blocked");
        drive(0, 0, pi, pi);
        sb.push_back(ex(2'b00, pi, 0, 1, 0, 0));
        step();
        check("to_unblock");
        drive(1, 0, pi, pi);
        sb.push_back(ex(2'b10, pi, 1, 0, 0, 0));
        step();
        check("to_regrant0");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Two-requester arbiter that shares one SPI/QSPI flash pin set, such as the STARTUPE2/STARTUPE3 configuration-flash port, between two SPI engines in the `clk` domain (for example a JTAG-bridge sequencer and a user-fabric flash controller). Ownership is transaction-level: a requester holds the pins from grant until it drops its request. Between owners, chip-select is forced high for a guaranteed gap. All pin outputs are registered so the flash never sees a combinational glitch on handover.

## Interface
- `GAP_CYCLES`, default 4: cycles of forced idle pins between owners; legal range 1..255.
- `TIMEOUT_CYCLES`, default 65535: maximum hold time while the other side waits; used only with `SPI_ARB_TIMEOUT_EN`.

Clock, reset and per-requester ports (x = 0 or 1):
- `clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous assert, active-low.
- `reqx` in 1: request; held high for the whole ownership.
- `gntx` out 1: grant, registered.
- `csnx`, `sckx` in 1: requester chip-select and clock.
- `dqx_o` in 4: requester data out.
- `dqx_oe` in 4: requester data output enable.

Shared flash pins and status:
- `flash_dq_i` in 4: flash data in, broadcast to both requesters unregistered.
- `flash_csn`, `flash_sck` out 1: registered pins.
- `flash_dq_o`, `flash_dq_oe` out 4: registered pins.
- `owner` out 1: last or current owner.
- `busy` out 1: high when state is not IDLE.
- `abort_err`, `timeout_err` out 1: one-cycle pulses.

## Operation
States:
- IDLE: no owner, pins idle.
- OWN0: requester 0 owns the pins.
- OWN1: requester 1 owns the pins.
- GAP: pins idle; a down-counter is loaded with `GAP_CYCLES-1` on entry.

Idle pin values: `flash_csn`=1, `flash_sck`=0, `flash_dq_o`=0, `flash_dq_oe`=0.

Transitions:
- IDLE → OWNx when `reqx` is high. If both are high, the grant goes to the requester not equal to the round-robin pointer `last`. `last` resets to 1, so requester 0 wins the first tie.
- OWNx → GAP when `reqx` is sampled low. `last` is updated to x.
- GAP → IDLE when the counter is 0. GAP therefore lasts exactly `GAP_CYCLES` cycles.

Grant and pin behaviour:
- `gntx` = 1 exactly while the state is OWNx.
- Each edge, the pin registers load requester x's `csnx`, `sckx`, `dqx_o` and `dqx_oe` if the next state is OWNx; otherwise they load the idle values.
- A non-owner's pin inputs are ignored entirely.

Release rules:
- If `reqx` drops while `csnx`=0, pins are still forced idle. `abort_err` pulses for one cycle in the first GAP cycle.
- If the previous owner re-requests during GAP while the other requester waits, the other wins the next IDLE decision. If no one else is waiting, the same owner is re-granted.

Reset:
- `rst_n` low at any time, including mid-transaction, immediately forces state IDLE, all grants 0, pins idle, `owner`=0, `last`=1, counters 0 and error pulses 0.

## Timing
- Request to grant: `reqx` sampled high in IDLE at edge t gives `gntx`=1 after edge t.
- Pin latency: the owner's signals sampled at edge n appear on the flash pins after edge n (one register).
- Handover: owner drops request, sampled at t. GAP covers t+1..t+`GAP_CYCLES`, IDLE is at t+`GAP_CYCLES`+1, and the new grant follows the next edge. The flash therefore sees `flash_csn`=1 for at least `GAP_CYCLES`+1 cycles.
- `flash_dq_i` is combinational; the requester owns its sampling timing.

## Configuration
`SPI_ARB_TIMEOUT_EN` defined:
- A 16-bit counter increments in OWNx while `req` of the other requester is high, and clears otherwise.
- When the count reaches `TIMEOUT_CYCLES`, the state goes to GAP, `gntx` drops and `timeout_err` pulses for one cycle.
- The revoked requester is ineligible until its `req` has been sampled low at least once.

`SPI_ARB_TIMEOUT_EN` undefined:
- No counter exists, `timeout_err` is tied 0, and ownership is unbounded.

## Structure
- Package `spi_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_OWN0`, `ST_OWN1`, `ST_GAP`);
  - the idle pin constants `PIN_IDLE_CSN`=1, `PIN_IDLE_SCK`=0, `PIN_IDLE_DQ`=4'h0 and `PIN_IDLE_OE`=4'h0;
  - the `OWNER_0` and `OWNER_1` encodings.
- One sub-module, `spi_arb_pin_reg`: a registered 2:1 pin mux with an idle-force input and async reset to idle values.
- The FSM, round-robin pointer and counters live in the top level.

## Test plan
- **Reset idle:** `rst_n` low → pins 1/0/0/0, `gnt0`=`gnt1`=0, `busy`=0. Release reset with `req0`=1 → `gnt0`=1 one edge later.
- **Simultaneous requests:** `req0`=`req1`=1 out of reset → `gnt0` first. `req0` drops → `flash_csn`=1 for ≥5 cycles (`GAP_CYCLES`=4) → `gnt1`=1. Next tie goes to requester 0.
- **Passthrough:** owner 1 drives `dq1_o`=4'hA with `dq1_oe`=4'hF while requester 0 toggles its own inputs → pins show 4'hA/4'hF one edge later. Requester 0's activity never appears on the pins.
- **Abort:** `req0` drops while `csn0`=0 → `flash_csn`=1 after the next edge, and `abort_err` is a single-cycle pulse.
- **Reset mid-transaction:** assert `rst_n` low while OWN1 is shifting → pins idle asynchronously (before the next edge) and the state is IDLE.
- **Timeout (with `SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** `req0` held while `req1` waits → `gnt0` drops after 16 cycles, `timeout_err` pulses, and `gnt1` follows after the gap. `req0` held high is not re-granted until it has toggled low.
